rv32m_wb_sched: RTL

- Write-port scheduler for the 32x32 integer register file.
- Shares the file's single write port between the in-order pipeline writeback (WB stage) and the multi-cycle M-extension mul/div unit.
- Tracks the single outstanding mul/div destination as a one-entry scoreboard, generates decode-stage hazard stalls, and buffers a completed mul/div result until the port is free.
- Sits between WB stage, mul/div unit, decode stage and the register-file write port.

---
 rtl/rv32m_wb_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rv32m_wb_sched.sv
// Register-file write-port arbiter between the WB stage and the multi-cycle mul/div unit.
// Also holds the one-entry mul/div destination scoreboard that drives decode hazard stalls.
module rv32m_wb_sched #(
    parameter int XLEN         = 32,
    parameter int AW           = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wb_valid,
    input  logic [AW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_wb_stall,
    input  logic            i_md_issue,
    input  logic [AW-1:0]   i_md_rd,
    input  logic            i_md_res_valid,
    input  logic [XLEN-1:0] i_md_res_data,
    output logic            o_md_res_ready,
    input  logic [AW-1:0]   i_id_rs1,
    input  logic [AW-1:0]   i_id_rs2,
    input  logic [AW-1:0]   i_id_rd,
    input  logic            i_id_md_op,
    output logic            o_id_stall,
    output logic            o_rf_we,
    output logic [AW-1:0]   o_rf_rd,
    output logic [XLEN-1:0] o_rf_data,
    output logic [1:0]      o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pend_rd_q, pend_rd_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;

    logic wb_req;
    logic starved;

    // Handshake: the mul/div result transfers on any cycle where i_md_res_valid and o_md_res_ready are both high.
    assign wb_req  = i_wb_valid && (i_wb_rd != '0);
    assign starved = (starve_cnt_q == 4'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pend_rd_q    <= '0;
            buf_data_q   <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_rd_q    <= pend_rd_d;
            buf_data_q   <= buf_data_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_rd_d    = pend_rd_q;
        buf_data_d   = buf_data_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_md_issue) begin
                    pend_rd_d = i_md_rd;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (i_md_res_valid) begin
                    // x0 results are dropped; otherwise buffer only if WB owns the port.
                    if ((pend_rd_q == '0) || !wb_req) begin
                        state_d = S_IDLE;
                    end else begin
                        buf_data_d   = i_md_res_data;
                        starve_cnt_d = '0;
                        state_d      = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!wb_req || starved) begin
                    state_d = S_IDLE;
                end else begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_rf_we        = wb_req;
        o_rf_rd        = i_wb_rd;
        o_rf_data      = i_wb_data;
        o_wb_stall     = 1'b0;
        o_md_res_ready = 1'b0;
        case (state_q)
            S_EXEC: begin
                o_md_res_ready = 1'b1;
                if (i_md_res_valid && (pend_rd_q != '0) && !wb_req) begin
                    o_rf_we   = 1'b1;
                    o_rf_rd   = pend_rd_q;
                    o_rf_data = i_md_res_data;
                end
            end
            S_WAIT: begin
                if (!wb_req || starved) begin
                    o_rf_we    = 1'b1;
                    o_rf_rd    = pend_rd_q;
                    o_rf_data  = buf_data_q;
                    o_wb_stall = wb_req;
                end
            end
            default: ;
        endcase
        if (rst) begin
            o_rf_we        = 1'b0;
            o_rf_rd        = '0;
            o_rf_data      = '0;
            o_wb_stall     = 1'b0;
            o_md_res_ready = 1'b0;
        end
    end

    // Stall stays up through the mul/div write cycle because state only returns to IDLE afterwards.
    always_comb begin
        o_id_stall = 1'b0;
        if ((state_q != S_IDLE) && (pend_rd_q != '0) &&
            ((i_id_rs1 == pend_rd_q) || (i_id_rs2 == pend_rd_q) || (i_id_rd == pend_rd_q)))
            o_id_stall = 1'b1;
        if (i_md_issue && (i_md_rd != '0) &&
            ((i_id_rs1 == i_md_rd) || (i_id_rs2 == i_md_rd) || (i_id_rd == i_md_rd)))
            o_id_stall = 1'b1;
        if (i_id_md_op && ((state_q != S_IDLE) || i_md_issue))
            o_id_stall = 1'b1;
        if (rst)
            o_id_stall = 1'b0;
    end

    assign o_dbg_state = state_q;

endmodule
